// File: rtl/accel_pkg.sv
// accel_pkg: shared opcode, error, state and vector types for the vector exchange unit
package accel_pkg;
  localparam int DATA_DEPTH_DEF = 8;
  localparam int ELEM_WIDTH_DEF = 16;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_COPY  = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MAX   = 3'd6
  } op_e;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_BAD_SRC = 2'd2
  } err_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_PEER,
    S_EXEC,
    S_DONE
  } state_e;
  typedef logic signed [ELEM_WIDTH_DEF-1:0] elem_t;
  typedef elem_t [DATA_DEPTH_DEF-1:0] vec_t;
  function automatic logic is_peer_op(input op_e op);
    return op inside {OP_COPY, OP_ADD, OP_SUB, OP_MAX};
  endfunction
endpackage

// File: rtl/vec_alu.sv
// vec_alu: lane-parallel add/sub/max on signed elements; SATURATE_EN clamps add/sub
module vec_alu
  import accel_pkg::*;
#(
  parameter int DATA_DEPTH = 8,
  parameter int ELEM_WIDTH = 16
) (
  input  op_e                                op,
  input  logic [DATA_DEPTH*ELEM_WIDTH-1:0]   a,
  input  logic [DATA_DEPTH*ELEM_WIDTH-1:0]   b,
  output logic [DATA_DEPTH*ELEM_WIDTH-1:0]   y
);
  localparam int EW = ELEM_WIDTH;
  for (genvar i = 0; i < DATA_DEPTH; i++) begin : g_lane
    logic signed [EW-1:0] x, z;
    logic [EW-1:0] r;
    assign x = a[i*EW +: EW];
    assign z = b[i*EW +: EW];
`ifdef SATURATE_EN
    logic signed [EW:0] s;
    assign s = op == OP_SUB ? {x[EW-1], x} - {z[EW-1], z} : {x[EW-1], x} + {z[EW-1], z};
    // differing top bits of the widened result mean the lane overflowed
    assign r = s[EW] != s[EW-1] ? {s[EW], {(EW-1){~s[EW]}}} : s[EW-1:0];
`else
    assign r = op == OP_SUB ? x - z : x + z;
`endif
    assign y[i*EW +: EW] = op == OP_MAX ? (x > z ? x : z) : r;
  end
endmodule

// File: rtl/vector_exchange_unit.sv
// vector_exchange_unit: vector accumulator with peer-bus ops; SATURATE_EN enables saturating add/sub
module vector_exchange_unit
  import accel_pkg::*;
#(
  parameter int UNIT_COUNT   = 4,
  parameter int DATA_DEPTH   = 8,
  parameter int ELEM_WIDTH   = 16,
  parameter int UID_W        = $clog2(UNIT_COUNT),
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [UID_W-1:0]                           unit_id,
  input  logic                                       cmd_valid,
  output logic                                       cmd_ready,
  input  logic [2:0]                                 cmd_op,
  input  logic [UID_W-1:0]                           cmd_src,
  input  logic [DATA_DEPTH*ELEM_WIDTH-1:0]           data_in,
  input  logic [UNIT_COUNT*DATA_DEPTH*ELEM_WIDTH-1:0] peer_data,
  input  logic [UNIT_COUNT-1:0]                      peer_valid,
  output logic [DATA_DEPTH*ELEM_WIDTH-1:0]           acc_out,
  output logic                                       acc_valid,
  output logic [DATA_DEPTH*ELEM_WIDTH-1:0]           res_data,
  output logic                                       res_valid,
  input  logic                                       res_ready,
  output logic                                       done,
  output logic [1:0]                                 err
);
  localparam int VW = DATA_DEPTH * ELEM_WIDTH;
  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  state_e           state;
  op_e              op_q;
  err_e             err_q;
  logic [UID_W-1:0] src_q;
  logic [VW-1:0]    din_q, acc, peer_vec, operand, alu_y;
  logic [CW-1:0]    cnt;
  logic             peer_ok, bad_src, self_src;
  always_comb begin
    peer_vec = '0;
    peer_ok  = 1'b0;
    for (int k = 0; k < UNIT_COUNT; k++)
      if (src_q == UID_W'(k)) begin
        peer_vec = peer_data[k*VW +: VW];
        peer_ok  = peer_valid[k];
      end
  end
  assign bad_src   = 32'(src_q) >= UNIT_COUNT;
  assign self_src  = src_q == unit_id;
  assign operand   = self_src ? acc : peer_vec;
  assign acc_out   = acc;
  assign cmd_ready = state == S_IDLE;
  assign done      = state == S_DONE && (!res_valid || res_ready);
  assign err       = err_q;
  vec_alu #(.DATA_DEPTH(DATA_DEPTH), .ELEM_WIDTH(ELEM_WIDTH)) u_alu (
    .op (op_q),
    .a  (acc),
    .b  (operand),
    .y  (alu_y)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      src_q     <= '0;
      din_q     <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
      cnt       <= '0;
      err_q     <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            op_q  <= op_e'(cmd_op);
            src_q <= cmd_src;
            din_q <= data_in;
            err_q <= ERR_NONE;
            state <= S_FETCH;
          end
        S_FETCH: begin
          cnt <= '0;
          // a bad source still passes through EXEC, which skips the update while err is set
          if (is_peer_op(op_q) && bad_src) begin
            err_q <= ERR_BAD_SRC;
            state <= S_EXEC;
          end else
            state <= is_peer_op(op_q) && !self_src ? S_WAIT_PEER : S_EXEC;
        end
        S_WAIT_PEER:
          if (peer_ok)
            state <= S_EXEC;
          else if (cnt == CW'(WAIT_TIMEOUT - 1)) begin
            err_q <= ERR_TIMEOUT;
            state <= S_DONE;
          end else
            cnt <= cnt + 1'b1;
        S_EXEC: begin
          state <= S_DONE;
          if (err_q == ERR_NONE)
            case (op_q)
              OP_LOAD: begin
                acc       <= din_q;
                acc_valid <= 1'b1;
              end
              OP_COPY: begin
                acc       <= operand;
                acc_valid <= 1'b1;
              end
              OP_ADD, OP_SUB, OP_MAX: acc <= alu_y;
              OP_STORE: begin
                res_data  <= acc;
                res_valid <= 1'b1;
              end
              default: ;
            endcase
        end
        S_DONE:
          if (!res_valid || res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_exchange_unit.sv
// tb_vector_exchange_unit: table-driven and scoreboard checks of vector_exchange_unit
module tb_vector_exchange_unit;
  import accel_pkg::*;
  typedef struct {
    logic [2:0]   uid;
    op_e          op;
    logic [2:0]   src;
    logic [127:0] din;
    logic [127:0] acc;
    logic         accv;
    logic [1:0]   err;
    int           lat;
  } vec_rec_t;
  typedef struct {
    logic [127:0] acc;
    logic         accv;
    logic [1:0]   err;
    int           lat;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] uid = '0, cmd_src = '0, cmd_op = '0;
  logic [127:0] data_in = '0;
  logic [639:0] pd = '0;
  logic [4:0] pv = '1;
  logic rr = 1'b1, cv4 = 1'b0, cv5 = 1'b0;
  logic [127:0] acc4, acc5, rd4, rd5;
  logic accv4, accv5, rdy4, rdy5, rv4, rv5, done4, done5;
  logic [1:0] err4, err5;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  vec_rec_t tbl[11];
  always #5 clk = ~clk;
  vector_exchange_unit u4 (
    .clk(clk), .rst_n(rst_n), .unit_id(uid[1:0]), .cmd_valid(cv4), .cmd_ready(rdy4),
    .cmd_op(cmd_op), .cmd_src(cmd_src[1:0]), .data_in(data_in), .peer_data(pd[511:0]),
    .peer_valid(pv[3:0]), .acc_out(acc4), .acc_valid(accv4), .res_data(rd4),
    .res_valid(rv4), .res_ready(rr), .done(done4), .err(err4)
  );
  vector_exchange_unit #(.UNIT_COUNT(5)) u5 (
    .clk(clk), .rst_n(rst_n), .unit_id(uid), .cmd_valid(cv5), .cmd_ready(rdy5),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .data_in(data_in), .peer_data(pd),
    .peer_valid(pv), .acc_out(acc5), .acc_valid(accv5), .res_data(rd5),
    .res_valid(rv5), .res_ready(rr), .done(done5), .err(err5)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] seq(input int s);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(s + k);
    return v;
  endfunction
  function automatic logic [127:0] fill(input int f);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(f);
    return v;
  endfunction
  function automatic logic [127:0] mk(input int l [8]);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(l[k]);
    return v;
  endfunction
  function automatic logic [127:0] vop(input op_e op, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] v;
    logic signed [15:0] ta, tb;
    int x, y, r;
    for (int k = 0; k < 8; k++) begin
      ta = a[k*16 +: 16];
      tb = b[k*16 +: 16];
      x = ta;
      y = tb;
      r = op == OP_ADD ? x + y : op == OP_SUB ? x - y : (x > y ? x : y);
`ifdef SATURATE_EN
      if (op != OP_MAX) r = r > 32767 ? 32767 : (r < -32768 ? -32768 : r);
`endif
      v[k*16 +: 16] = r[15:0];
    end
    return v;
  endfunction
  task automatic run_cmd(input bit s5, input logic [2:0] u, input op_e op, input logic [2:0] src,
                         input logic [127:0] din, input logic [127:0] e_acc, input logic e_accv,
                         input logic [1:0] e_err, input int e_lat, input int raise_at, input int raise_bit);
    exp_t e;
    int lat;
    e.acc = e_acc; e.accv = e_accv; e.err = e_err; e.lat = e_lat;
    exp_q.push_back(e);
    @(negedge clk);
    chk("cmd_ready_idle", s5 ? rdy5 : rdy4, 1);
    uid = u; cmd_op = op; cmd_src = src; data_in = din;
    if (s5) cv5 = 1'b1; else cv4 = 1'b1;
    @(posedge clk);
    #1 cv4 = 1'b0; cv5 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == raise_at) pv[raise_bit] = 1'b1;
      if (s5 ? done5 : done4) break;
    end
    e = exp_q.pop_front();
    chk($sformatf("%s_latency", op.name()), lat, e.lat);
    chk($sformatf("%s_acc", op.name()), s5 ? acc5 : acc4, e.acc);
    chk($sformatf("%s_acc_valid", op.name()), s5 ? accv5 : accv4, e.accv);
    chk($sformatf("%s_err", op.name()), s5 ? err5 : err4, e.err);
  endtask
  initial begin
    logic [127:0] p0, pat2;
    p0   = mk('{32767, -32768, -1, 1, 0, 100, -100, 32766});
    pat2 = mk('{-5, 7, -32768, 32767, 0, -1, 100, -100});
    pd[0*128 +: 128] = p0;
    pd[1*128 +: 128] = fill(16'h7FFF);
    pd[2*128 +: 128] = fill(1);
    pd[3*128 +: 128] = seq(10);
    pd[4*128 +: 128] = fill(4);
    tbl[0]  = '{3'd1, OP_LOAD,  3'd0, seq(1), seq(1), 1'b1, 2'd0, 3};
    tbl[1]  = '{3'd1, OP_ADD,   3'd1, '0, vop(OP_ADD, tbl[0].acc, tbl[0].acc), 1'b1, 2'd0, 3};
    tbl[2]  = '{3'd1, OP_SUB,   3'd3, '0, vop(OP_SUB, tbl[1].acc, seq(10)), 1'b1, 2'd0, 4};
    tbl[3]  = '{3'd1, OP_MAX,   3'd3, '0, vop(OP_MAX, tbl[2].acc, seq(10)), 1'b1, 2'd0, 4};
    tbl[4]  = '{3'd1, OP_NOP,   3'd0, '0, tbl[3].acc, 1'b1, 2'd0, 3};
    tbl[5]  = '{3'd1, OP_COPY,  3'd0, '0, p0, 1'b1, 2'd0, 4};
    tbl[6]  = '{3'd1, OP_ADD,   3'd2, '0, vop(OP_ADD, p0, fill(1)), 1'b1, 2'd0, 4};
    tbl[7]  = '{3'd1, OP_SUB,   3'd2, '0, vop(OP_SUB, tbl[6].acc, fill(1)), 1'b1, 2'd0, 4};
    tbl[8]  = '{3'd1, OP_LOAD,  3'd0, pat2, pat2, 1'b1, 2'd0, 3};
    tbl[9]  = '{3'd1, OP_MAX,   3'd3, '0, vop(OP_MAX, pat2, seq(10)), 1'b1, 2'd0, 4};
    tbl[10] = '{3'd0, OP_LOAD,  3'd0, fill(3), fill(3), 1'b1, 2'd0, 3};
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", rdy4, 1);
    chk("rst_acc", acc4, 0);
    chk("rst_acc_valid", accv4, 0);
    chk("rst_done", done4, 0);
    chk("rst_err", err4, 0);
    chk("rst_res_valid", rv4, 0);
    chk("rst_res_data", rd4, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++)
      run_cmd(0, tbl[i].uid, tbl[i].op, tbl[i].src, tbl[i].din, tbl[i].acc, tbl[i].accv,
              tbl[i].err, tbl[i].lat, -1, 0);
    pd[2*128 +: 128] = fill(5);
    pv = 5'b11011;
    run_cmd(0, 3'd0, OP_ADD, 3'd2, '0, fill(8), 1'b1, 2'd0, 7, 5, 2);
    pv[3] = 1'b0;
    run_cmd(0, 3'd0, OP_COPY, 3'd3, '0, fill(8), 1'b1, 2'd1, 17, -1, 0);
    run_cmd(0, 3'd0, OP_NOP, 3'd0, '0, fill(8), 1'b1, 2'd0, 3, -1, 0);
    run_cmd(0, 3'd0, OP_STORE, 3'd0, '0, fill(8), 1'b1, 2'd0, 3, -1, 0);
    chk("store_res_valid", rv4, 1);
    chk("store_res_data", rd4, fill(8));
    @(posedge clk);
    #1 chk("store_res_valid_drop", rv4, 0);
    run_cmd(0, 3'd0, OP_LOAD, 3'd0, seq(20), seq(20), 1'b1, 2'd0, 3, -1, 0);
    rr = 1'b0;
    @(negedge clk);
    cmd_op = OP_STORE;
    cv4 = 1'b1;
    @(posedge clk);
    #1 cv4 = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("stall_res_valid", rv4, 1);
      chk("stall_res_data", rd4, seq(20));
      chk("stall_cmd_ready", rdy4, 0);
      chk("stall_done", done4, 0);
    end
    rr = 1'b1;
    #1 chk("stall_handshake_done", done4, 1);
    @(posedge clk);
    #1 chk("stall_res_valid_drop", rv4, 0);
    chk("stall_done_drop", done4, 0);
    run_cmd(1, 3'd0, OP_LOAD, 3'd0, fill(9), fill(9), 1'b1, 2'd0, 3, -1, 0);
    run_cmd(1, 3'd0, OP_ADD, 3'd5, '0, fill(9), 1'b1, 2'd2, 3, -1, 0);
    run_cmd(1, 3'd0, OP_MAX, 3'd7, '0, fill(9), 1'b1, 2'd2, 3, -1, 0);
    run_cmd(1, 3'd0, OP_NOP, 3'd0, '0, fill(9), 1'b1, 2'd0, 3, -1, 0);
    @(negedge clk);
    uid = 3'd0; cmd_op = OP_COPY; cmd_src = 3'd3;
    cv4 = 1'b1;
    @(posedge clk);
    #1 cv4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_cmd_ready", rdy4, 0);
    rst_n = 1'b0;
    #1 chk("arst_acc", acc4, 0);
    chk("arst_acc_valid", accv4, 0);
    chk("arst_cmd_ready", rdy4, 1);
    chk("arst_done", done4, 0);
    chk("arst_err", err4, 0);
    chk("arst_res_valid", rv4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", rdy4, 1);
    chk("post_rst_done", done4, 0);
    run_cmd(0, 3'd0, OP_LOAD, 3'd0, fill(2), fill(2), 1'b1, 2'd0, 3, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
